// File: rtl/backlight_duty_ctrl_if.sv
// Host-side bundle for the backlight brightness controller:
// target writes and activity in, duty and status out.
interface backlight_duty_ctrl_if;
    logic       wr_en;
    logic [4:0] wr_data;
    logic       activity;
    logic [4:0] Duty_Val;
    logic       fading;
    logic       dimmed;

    modport master (
        output wr_en,
        output wr_data,
        output activity,
        input  Duty_Val,
        input  fading,
        input  dimmed
    );

    modport slave (
        input  wr_en,
        input  wr_data,
        input  activity,
        output Duty_Val,
        output fading,
        output dimmed
    );
endinterface

// File: rtl/backlight_duty_ctrl.sv
// Backlight brightness slew controller: fades the PWM duty toward a
// host target one LSB per step tick and auto-dims after inactivity.
module backlight_duty_ctrl #(
    parameter int STEP_DIV     = 1024,
    parameter int IDLE_TICKS   = 4096,
    parameter int DIM_LEVEL    = 4,
    parameter int DEFAULT_DUTY = 16
) (
    input  logic                  CLK,
    input  logic                  RST,
    backlight_duty_ctrl_if.slave  bus
);

    localparam logic [15:0] PRESC_MAX = 16'(STEP_DIV - 1);
    localparam logic [15:0] IDLE_MAX  = 16'(IDLE_TICKS - 1);
    localparam logic        IDLE_EN   = (IDLE_TICKS != 0);
    localparam logic [4:0]  DIM_L     = 5'(DIM_LEVEL);
    localparam logic [4:0]  DEF_D     = 5'(DEFAULT_DUTY);

    localparam logic [0:0] ST_ACTIVE = 1'b0;
    localparam logic [0:0] ST_DIMMED = 1'b1;

    logic [15:0] presc;
    logic [15:0] idle_cnt;
    logic [15:0] idle_nxt;
    logic [4:0]  target;
    logic [4:0]  target_nxt;
    logic [4:0]  duty;
    logic [4:0]  duty_nxt;
    logic [4:0]  eff;
    logic [4:0]  eff_nxt;
    logic [0:0]  state;
    logic [0:0]  state_nxt;
    logic        fading_q;
    logic        tick;
    logic        wake;

    assign tick = (presc == PRESC_MAX);
    assign wake = bus.activity | bus.wr_en;

    assign eff = (state == ST_DIMMED && target > DIM_L) ? DIM_L : target;
    assign eff_nxt = (state_nxt == ST_DIMMED && target_nxt > DIM_L)
                   ? DIM_L : target_nxt;

    assign bus.Duty_Val = duty;
    assign bus.fading   = fading_q;
    assign bus.dimmed   = (state == ST_DIMMED);

    // Next-state logic: target load, one-LSB fade step, idle/dim FSM.
    always_comb begin
        target_nxt = bus.wr_en ? bus.wr_data : target;
        duty_nxt   = duty;
        state_nxt  = state;
        idle_nxt   = idle_cnt;

        if (tick && duty < eff) begin
            duty_nxt = duty + 5'd1;
        end else if (tick && duty > eff) begin
            duty_nxt = duty - 5'd1;
        end

        if (wake) begin
            idle_nxt  = 16'd0;
            state_nxt = ST_ACTIVE;
        end else if (state == ST_ACTIVE && tick) begin
            if (IDLE_EN && idle_cnt == IDLE_MAX) begin
                state_nxt = ST_DIMMED;
            end else begin
                idle_nxt = idle_cnt + 16'd1;
            end
        end
    end

    // Register update; reset overrides every same-cycle event.
    always_ff @(posedge CLK) begin
        if (RST) begin
            presc    <= 16'd0;
            idle_cnt <= 16'd0;
            target   <= DEF_D;
            duty     <= 5'd0;
            state    <= ST_ACTIVE;
            fading_q <= 1'b0;
        end else begin
            presc    <= tick ? 16'd0 : presc + 16'd1;
            idle_cnt <= idle_nxt;
            target   <= target_nxt;
            duty     <= duty_nxt;
            state    <= state_nxt;
            fading_q <= (duty_nxt != eff_nxt);
        end
    end

endmodule

// File: tb/tb_backlight_duty_ctrl.sv
// Directed bench for backlight_duty_ctrl with STEP_DIV=4,
// IDLE_TICKS=8, DIM_LEVEL=4, DEFAULT_DUTY=16.
module tb_backlight_duty_ctrl;

    logic CLK = 1'b0;
    logic RST = 1'b1;
    int   cyc = 0;
    int   errors = 0;
    int   checks = 0;

    backlight_duty_ctrl_if bif ();

    backlight_duty_ctrl #(
        .STEP_DIV     (4),
        .IDLE_TICKS   (8),
        .DIM_LEVEL    (4),
        .DEFAULT_DUTY (16)
    ) dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bif.slave)
    );

    always #5 CLK = ~CLK;

    // Advance one edge; inputs change and outputs are sampled 1ns later.
    task automatic step();
        @(posedge CLK);
        #1;
        cyc++;
    endtask

    task automatic run_to(input int c);
        while (cyc < c) step();
    endtask

    task automatic test_reset();
        RST = 1'b1;
        bif.wr_en = 1'b0;
        bif.wr_data = 5'd0;
        bif.activity = 1'b1;
        step();
        step();
        checks++;
        if (bif.Duty_Val !== 5'd0) begin
            errors++;
            $display("FAIL reset_duty got %0d want 0", bif.Duty_Val);
        end
        checks++;
        if (bif.fading !== 1'b0 || bif.dimmed !== 1'b0) begin
            errors++;
            $display("FAIL reset_flags got f=%b d=%b want f=0 d=0",
                     bif.fading, bif.dimmed);
        end
        RST = 1'b0;
        cyc = 0;
        step();
        checks++;
        if (bif.fading !== 1'b1 || bif.Duty_Val !== 5'd0) begin
            errors++;
            $display("FAIL reset_release got f=%b duty=%0d want f=1 duty=0",
                     bif.fading, bif.Duty_Val);
        end
    endtask

    task automatic test_soft_start(input string tag);
        run_to(3);
        checks++;
        if (bif.Duty_Val !== 5'd0) begin
            errors++;
            $display("FAIL %s_c3 duty got %0d want 0", tag, bif.Duty_Val);
        end
        run_to(4);
        checks++;
        if (bif.Duty_Val !== 5'd1) begin
            errors++;
            $display("FAIL %s_c4 duty got %0d want 1", tag, bif.Duty_Val);
        end
        run_to(63);
        checks++;
        if (bif.Duty_Val !== 5'd15 || bif.fading !== 1'b1) begin
            errors++;
            $display("FAIL %s_c63 got duty=%0d f=%b want duty=15 f=1",
                     tag, bif.Duty_Val, bif.fading);
        end
        run_to(64);
        checks++;
        if (bif.Duty_Val !== 5'd16 || bif.fading !== 1'b0
            || bif.dimmed !== 1'b0) begin
            errors++;
            $display("FAIL %s_c64 got duty=%0d f=%b d=%b want 16 0 0",
                     tag, bif.Duty_Val, bif.fading, bif.dimmed);
        end
    endtask

    task automatic test_auto_dim();
        bif.activity = 1'b0;
        run_to(95);
        checks++;
        if (bif.dimmed !== 1'b0) begin
            errors++;
            $display("FAIL dim_early got %b want 0", bif.dimmed);
        end
        run_to(96);
        checks++;
        if (bif.dimmed !== 1'b1 || bif.Duty_Val !== 5'd16
            || bif.fading !== 1'b1) begin
            errors++;
            $display("FAIL dim_8th_tick got d=%b duty=%0d f=%b want 1 16 1",
                     bif.dimmed, bif.Duty_Val, bif.fading);
        end
        run_to(100);
        checks++;
        if (bif.Duty_Val !== 5'd15) begin
            errors++;
            $display("FAIL dim_first_step got %0d want 15", bif.Duty_Val);
        end
        run_to(143);
        checks++;
        if (bif.Duty_Val !== 5'd5) begin
            errors++;
            $display("FAIL dim_c143 got %0d want 5", bif.Duty_Val);
        end
        run_to(144);
        checks++;
        if (bif.Duty_Val !== 5'd4 || bif.fading !== 1'b0) begin
            errors++;
            $display("FAIL dim_floor got duty=%0d f=%b want 4 0",
                     bif.Duty_Val, bif.fading);
        end
        run_to(160);
        checks++;
        if (bif.Duty_Val !== 5'd4 || bif.dimmed !== 1'b1) begin
            errors++;
            $display("FAIL dim_hold got duty=%0d d=%b want 4 1",
                     bif.Duty_Val, bif.dimmed);
        end
    endtask

    task automatic test_wake();
        bif.activity = 1'b1;
        step();
        bif.activity = 1'b0;
        checks++;
        if (bif.dimmed !== 1'b0 || bif.Duty_Val !== 5'd4
            || bif.fading !== 1'b1) begin
            errors++;
            $display("FAIL wake_edge got d=%b duty=%0d f=%b want 0 4 1",
                     bif.dimmed, bif.Duty_Val, bif.fading);
        end
        run_to(164);
        checks++;
        if (bif.Duty_Val !== 5'd5) begin
            errors++;
            $display("FAIL wake_step got %0d want 5", bif.Duty_Val);
        end
        bif.activity = 1'b1;
        run_to(208);
        checks++;
        if (bif.Duty_Val !== 5'd16 || bif.fading !== 1'b0) begin
            errors++;
            $display("FAIL wake_full got duty=%0d f=%b want 16 0",
                     bif.Duty_Val, bif.fading);
        end
    endtask

    task automatic test_coincident();
        bif.activity = 1'b0;
        run_to(239);
        bif.activity = 1'b1;
        run_to(240);
        bif.activity = 1'b0;
        checks++;
        if (bif.dimmed !== 1'b0) begin
            errors++;
            $display("FAIL coincide_no_dim got %b want 0", bif.dimmed);
        end
        run_to(271);
        checks++;
        if (bif.dimmed !== 1'b0) begin
            errors++;
            $display("FAIL coincide_restart got %b want 0", bif.dimmed);
        end
        run_to(272);
        checks++;
        if (bif.dimmed !== 1'b1) begin
            errors++;
            $display("FAIL coincide_later_dim got %b want 1", bif.dimmed);
        end
        bif.activity = 1'b1;
        step();
        checks++;
        if (bif.dimmed !== 1'b0 || bif.Duty_Val !== 5'd16) begin
            errors++;
            $display("FAIL coincide_wake got d=%b duty=%0d want 0 16",
                     bif.dimmed, bif.Duty_Val);
        end
    endtask

    task automatic test_extremes();
        bif.wr_en = 1'b1;
        bif.wr_data = 5'd31;
        step();
        bif.wr_en = 1'b0;
        run_to(276);
        checks++;
        if (bif.Duty_Val !== 5'd17) begin
            errors++;
            $display("FAIL max_first got %0d want 17", bif.Duty_Val);
        end
        run_to(332);
        checks++;
        if (bif.Duty_Val !== 5'd31 || bif.fading !== 1'b0) begin
            errors++;
            $display("FAIL max_reach got duty=%0d f=%b want 31 0",
                     bif.Duty_Val, bif.fading);
        end
        run_to(340);
        checks++;
        if (bif.Duty_Val !== 5'd31) begin
            errors++;
            $display("FAIL max_nowrap got %0d want 31", bif.Duty_Val);
        end
        bif.wr_en = 1'b1;
        bif.wr_data = 5'd0;
        step();
        bif.wr_en = 1'b0;
        run_to(344);
        checks++;
        if (bif.Duty_Val !== 5'd30) begin
            errors++;
            $display("FAIL zero_first got %0d want 30", bif.Duty_Val);
        end
        run_to(464);
        checks++;
        if (bif.Duty_Val !== 5'd0 || bif.fading !== 1'b0) begin
            errors++;
            $display("FAIL zero_reach got duty=%0d f=%b want 0 0",
                     bif.Duty_Val, bif.fading);
        end
        run_to(472);
        checks++;
        if (bif.Duty_Val !== 5'd0) begin
            errors++;
            $display("FAIL zero_nowrap got %0d want 0", bif.Duty_Val);
        end
    endtask

    task automatic test_retarget();
        bif.wr_en = 1'b1;
        bif.wr_data = 5'd16;
        step();
        bif.wr_en = 1'b0;
        run_to(512);
        checks++;
        if (bif.Duty_Val !== 5'd10) begin
            errors++;
            $display("FAIL retgt_at10 got %0d want 10", bif.Duty_Val);
        end
        run_to(515);
        bif.wr_en = 1'b1;
        bif.wr_data = 5'd6;
        step();
        bif.wr_en = 1'b0;
        checks++;
        if (bif.Duty_Val !== 5'd11 || bif.fading !== 1'b1) begin
            errors++;
            $display("FAIL retgt_same_edge got duty=%0d f=%b want 11 1",
                     bif.Duty_Val, bif.fading);
        end
        run_to(520);
        checks++;
        if (bif.Duty_Val !== 5'd10) begin
            errors++;
            $display("FAIL retgt_down got %0d want 10", bif.Duty_Val);
        end
        run_to(536);
        checks++;
        if (bif.Duty_Val !== 5'd6 || bif.fading !== 1'b0) begin
            errors++;
            $display("FAIL retgt_settle got duty=%0d f=%b want 6 0",
                     bif.Duty_Val, bif.fading);
        end
        run_to(544);
        checks++;
        if (bif.Duty_Val !== 5'd6) begin
            errors++;
            $display("FAIL retgt_hold got %0d want 6", bif.Duty_Val);
        end
    endtask

    task automatic test_reset_mid_fade();
        bif.wr_en = 1'b1;
        bif.wr_data = 5'd12;
        step();
        bif.wr_en = 1'b0;
        run_to(556);
        checks++;
        if (bif.Duty_Val !== 5'd9) begin
            errors++;
            $display("FAIL rst_pre got %0d want 9", bif.Duty_Val);
        end
        RST = 1'b1;
        bif.wr_en = 1'b1;
        bif.wr_data = 5'd31;
        step();
        RST = 1'b0;
        bif.wr_en = 1'b0;
        cyc = 0;
        checks++;
        if (bif.Duty_Val !== 5'd0 || bif.dimmed !== 1'b0
            || bif.fading !== 1'b0) begin
            errors++;
            $display("FAIL rst_mid got duty=%0d d=%b f=%b want 0 0 0",
                     bif.Duty_Val, bif.dimmed, bif.fading);
        end
        test_soft_start("rst_soft");
        run_to(80);
        checks++;
        if (bif.Duty_Val !== 5'd16) begin
            errors++;
            $display("FAIL rst_target got %0d want 16", bif.Duty_Val);
        end
    endtask

    initial begin
        test_reset();
        test_soft_start("soft");
        test_auto_dim();
        test_wake();
        test_coincident();
        test_extremes();
        test_retarget();
        test_reset_mid_fade();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/backlight_duty_ctrl.md
# backlight_duty_ctrl

Upstream brightness controller for the LCD backlight PWM stage. It holds a host-written 5-bit brightness target and slews its `Duty_Val` output toward that target one LSB per step tick, giving soft start and fades. After a programmable inactivity period it auto-dims to a lower level, and restores full brightness on any activity. `Duty_Val` drives the PWM backlight generator's duty input directly.

## Interface
- `STEP_DIV`, default 1024: CLK cycles per fade step tick (range 2..65535).
- `IDLE_TICKS`, default 4096: step ticks without activity before auto-dim (0 disables auto-dim; max 65535).
- `DIM_LEVEL`, default 4: brightness ceiling while dimmed (5-bit).
- `DEFAULT_DUTY`, default 16: target value after reset (5-bit).

Ports:
- `CLK` in, 1 bit: single clock; all logic is on its rising edge.
- `RST` in, 1 bit: synchronous, active-high reset.
- `wr_en` in, 1 bit: one-cycle strobe that loads `wr_data` into the target register.
- `wr_data` in, 5 bits: new brightness target (0 = off, 31 = max).
- `activity` in, 1 bit: level/pulse from the key/touch/host logic; high in any cycle counts as activity.
- `Duty_Val` out, 5 bits: registered duty value to the PWM stage.
- `fading` out, 1 bit: registered; high while `Duty_Val` ≠ effective target.
- `dimmed` out, 1 bit: registered; high in DIMMED state.

## Operation
- Prescaler: 16-bit counter `presc`, free-running from reset and never restarted by writes. `tick` is high in the cycle where `presc == STEP_DIV-1`; `presc` then wraps to 0.
- Target register `target[4:0]`: loaded with `wr_data` on the edge where `wr_en` = 1. A write mid-fade retargets immediately; the fade continues from the current `Duty_Val`.
- Effective target: `eff = dimmed ? min(target, DIM_LEVEL) : target`.
- Fade engine: on `tick`, `Duty_Val` increments if `Duty_Val < eff`, decrements if `Duty_Val > eff`, and holds if equal. The step is exactly ±1; there is no wrap at 0 or 31.
- State machine with two states:
  - ACTIVE: `idle_cnt` (16-bit) increments on each `tick`. When `tick` fires with `idle_cnt == IDLE_TICKS-1` and `IDLE_TICKS` ≠ 0, the state goes to DIMMED and `idle_cnt` holds.
  - DIMMED: on `activity` or `wr_en`, the state goes to ACTIVE.
  - In both states, `activity` or `wr_en` clears `idle_cnt` to 0 on that edge.
- Simultaneous events:
  - Activity and timeout on the same edge: activity wins; the state stays ACTIVE and `idle_cnt` = 0.
  - `wr_en` and `tick` on the same edge: the step uses the old `eff`, and the new target applies from the next tick.
- `fading` and `dimmed` are registered and reflect the post-edge values of `Duty_Val`, `eff` and state.

## Timing
- Reset values: `Duty_Val` = 0, `fading` = 0, `dimmed` = 0, `target` = `DEFAULT_DUTY`, `presc` = 0, `idle_cnt` = 0, state ACTIVE. `fading` rises on the first edge after reset release if `DEFAULT_DUTY` ≠ 0, which produces the soft start.
- First tick occurs `STEP_DIV` cycles after reset deassertion. A full 0→31 fade takes 31·`STEP_DIV` cycles.
- Write-to-first-step latency is 1..`STEP_DIV` cycles, depending on prescaler phase.
- Activity-to-undim: `dimmed` falls on the edge that samples `activity`. Brightness restores at 1 LSB per tick.
- `RST` asserted mid-fade: all state returns to reset values on that edge, regardless of `wr_en`, `activity` or `tick` in the same cycle.

## Test plan
Parameters for all scenarios: `STEP_DIV`=4, `IDLE_TICKS`=8, `DIM_LEVEL`=4, `DEFAULT_DUTY`=16.

- Soft start: release `RST` and hold `activity`=1.
  - `Duty_Val` = 1 after cycle 4 and 16 after cycle 64; `fading` then falls; `dimmed` stays 0.
- Retarget mid-fade: at `Duty_Val`=10 while rising, write `wr_data`=6.
  - `Duty_Val` goes 11 or 10 (per the same-edge rule), then falls 1 per 4 cycles to 6 and holds; `fading`=0 at 6.
- Auto-dim: settle at 16, drop `activity` to 0.
  - `dimmed`=1 on the 8th tick after the last activity, then `Duty_Val` falls 16→4 over 12 ticks.
- Wake: pulse `activity` for 1 cycle while dimmed at 4.
  - `dimmed`=0 next edge; `Duty_Val` ramps to 16.
- Extremes and corner cases:
  - Write 31: `Duty_Val` saturates at 31, with no wrap.
  - Write 0: `Duty_Val` holds at 0.
  - `activity` coincident with the timeout tick: `dimmed` stays 0.
- Reset mid-fade: assert `RST` for 1 cycle at `Duty_Val`=9.
  - `Duty_Val`=0 and `dimmed`=0 next edge; soft start repeats to 16.
